// File: rtl/mem_map_pkg.sv
// Shared address-map constants and region decode for memory_responder.
package mem_map_pkg;

  // MMIO register offsets within the 4 KiB window
  localparam logic [11:0] OFF_TX_DATA = 12'h000;
  localparam logic [11:0] OFF_STATUS  = 12'h004;
  localparam logic [11:0] OFF_LEDS    = 12'h008;
  localparam logic [11:0] OFF_CYCLE   = 12'h00C;

  // STATUS register bit positions
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  // RAM takes priority; MMIO is matched on the 4 KiB page number only.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    region_e r;
    if (addr < ram_bytes)                       r = REG_RAM;
    else if (addr[31:12] == mmio_base[31:12])   r = REG_MMIO;
    else                                        r = REG_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/memory_responder_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so count = wr - rd.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    head
);

  logic [AW:0] rd_q, rd_d;
  logic [AW:0] wr_q, wr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign count   = wr_q - rd_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem_q[rd_q[AW-1:0]];
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Pointer advance for this edge
  always_comb begin
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
  end

  // Pointer registers, reset to empty
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: word RAM plus MMIO window (TX FIFO, STATUS, LEDS, CYCLE).
// Read data is registered: data_out reflects the address sampled at the previous edge.
module memory_responder
  import mem_map_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter string       INIT_FILE  = "",
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  leds,
  output logic        fault
);

  localparam int          RAW       = $clog2(MEM_WORDS);
  localparam int          FAW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  region_e         region;
  logic [RAW-1:0]  ram_idx;
  logic [11:0]     mmio_off;
  logic            hit_tx, hit_status, hit_leds, hit_cycle;
  logic            bad_access;

  logic [31:0]     ram_q [MEM_WORDS];

  logic [31:0]     data_out_q, data_out_d;
  logic [7:0]      leds_q, leds_d;
  logic            ovf_q, ovf_d;
  logic            fault_q, fault_d;
  logic [31:0]     cycle_q, cycle_d;

  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [FAW:0]    fifo_count;
  logic [7:0]      fifo_head;
  logic [31:0]     cnt_ext;
  logic [31:0]     status_w;

  // Address decode; low two address bits never matter
  assign region     = decode_region(address, RAM_BYTES, MMIO_BASE);
  assign ram_idx    = address[RAW+1:2];
  assign mmio_off   = {address[11:2], 2'b00};
  assign hit_tx     = (region == REG_MMIO) && (mmio_off == OFF_TX_DATA);
  assign hit_status = (region == REG_MMIO) && (mmio_off == OFF_STATUS);
  assign hit_leds   = (region == REG_MMIO) && (mmio_off == OFF_LEDS);
  assign hit_cycle  = (region == REG_MMIO) && (mmio_off == OFF_CYCLE);
  assign bad_access = (region == REG_UNMAPPED) ||
                      ((region == REG_MMIO) && !(hit_tx || hit_status || hit_leds || hit_cycle));

  assign fifo_push  = we && hit_tx;
  assign fifo_pop   = tx_valid && tx_ready;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_in[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;
  assign data_out = data_out_q;
  assign leds     = leds_q;
  assign fault    = fault_q;

  // RAM write port; reset blocks the write but never clears contents
  always_ff @(posedge clk) begin
    if (!reset && we && (region == REG_RAM)) ram_q[ram_idx] <= data_in;
  end

  // STATUS word assembly, zero-extended
  always_comb begin
    cnt_ext                             = 32'(fifo_count);
    status_w                            = '0;
    status_w[STAT_EMPTY_BIT]            = fifo_empty;
    status_w[STAT_FULL_BIT]             = fifo_full;
    status_w[STAT_OVF_BIT]              = ovf_q;
    status_w[STAT_COUNT_LSB +: 8]       = cnt_ext[7:0];
  end

  // Read mux and next-state for MMIO registers (all from pre-edge values)
  always_comb begin
    data_out_d = '0;
    leds_d     = leds_q;
    ovf_d      = ovf_q;
    fault_d    = fault_q | bad_access;
    cycle_d    = cycle_q + 32'd1;

    case (region)
      REG_RAM:  data_out_d = ram_q[ram_idx];
      REG_MMIO: begin
        if (hit_status)     data_out_d = status_w;
        else if (hit_leds)  data_out_d = {24'h0, leds_q};
        else if (hit_cycle) data_out_d = cycle_q;
        else                data_out_d = '0;
      end
      default:  data_out_d = '0;
    endcase

    if (we && hit_leds) leds_d = data_in[7:0];
    if (we && hit_status && data_in[STAT_OVF_BIT]) ovf_d = 1'b0;
    // Set after clear so a simultaneous drop wins over the clear
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Register update; reset dominates every other action
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      leds_q     <= '0;
      ovf_q      <= 1'b0;
      fault_q    <= 1'b0;
      cycle_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      leds_q     <= leds_d;
      ovf_q      <= ovf_d;
      fault_q    <= fault_d;
      cycle_q    <= cycle_d;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed + random bench for memory_responder against a queue-based reference model.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h8000_0004;
  logic [31:0] data_in = '0;
  logic        we = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [7:0]  leds;
  logic        fault;

  always #5 clk = ~clk;

  memory_responder dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .leds     (leds),
    .fault    (fault)
  );

  // Reference model state
  logic [31:0] ram_m [1024];
  bit          ram_w [1024];
  logic [7:0]  q_m[$];
  bit          ovf_m;
  bit          fault_m;
  logic [7:0]  leds_m;
  logic [31:0] cyc_m;

  int          n_vec = 0;
  int          n_err = 0;
  string       cur_tag = "init";
  bit          dep_en = 1'b0;
  logic [31:0] dep_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", cur_tag, tag, obs, exp);
    end
  endtask

  // Expected read value from the model's pre-edge state
  task automatic model_read(input logic [31:0] a, output logic [31:0] v,
                            output bit known, output bit bad);
    int unsigned off;
    v = 32'h0; known = 1'b1; bad = 1'b0;
    if (a < 32'd4096) begin
      v = ram_m[a[11:2]];
      known = ram_w[a[11:2]];
    end else if (a[31:12] == 20'h80000) begin
      off = a[11:2];
      case (off)
        0: v = 32'h0;
        1: v = (q_m.size() << 8) | (32'(ovf_m) << 2) | ((q_m.size() == 8) ? 32'd2 : 32'd0)
               | ((q_m.size() == 0) ? 32'd1 : 32'd0);
        2: v = {24'h0, leds_m};
        3: v = cyc_m;
        default: begin v = 32'h0; bad = 1'b1; end
      endcase
    end else begin
      bad = 1'b1;
    end
  endtask

  // One clock edge: drive at negedge, advance model, check #1 after posedge
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic rdy);
    logic [31:0] exp_do;
    bit          known, bad, is_mmio, pop, ovf_set;
    int unsigned off;
    @(negedge clk);
    reset = r; address = a; data_in = d; we = w; tx_ready = rdy;
    if (dep_en) begin
      dut.cycle_q = dep_val;
      cyc_m = dep_val;
      dep_en = 1'b0;
    end
    if (r) begin
      exp_do = '0; known = 1'b1;
      q_m.delete(); ovf_m = 0; fault_m = 0; leds_m = '0; cyc_m = '0;
    end else begin
      model_read(a, exp_do, known, bad);
      is_mmio = (a >= 32'd4096) && (a[31:12] == 20'h80000);
      off     = a[11:2];
      pop     = (q_m.size() != 0) && rdy;
      ovf_set = 1'b0;
      if (pop) void'(q_m.pop_front());
      if (w && is_mmio && off == 0) begin
        if (q_m.size() < 8) q_m.push_back(d[7:0]);
        else ovf_set = 1'b1;
      end
      if (w && is_mmio && off == 1 && d[2]) ovf_m = 1'b0;
      if (ovf_set) ovf_m = 1'b1;
      if (w && is_mmio && off == 2) leds_m = d[7:0];
      if (w && a < 32'd4096) begin ram_m[a[11:2]] = d; ram_w[a[11:2]] = 1'b1; end
      if (bad) fault_m = 1'b1;
      cyc_m = cyc_m + 32'd1;
    end
    @(posedge clk);
    #1;
    if (known) chk("data_out", data_out, exp_do);
    chk("tx_valid", {31'h0, tx_valid}, (q_m.size() != 0) ? 32'd1 : 32'd0);
    if (q_m.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, q_m[0]});
    chk("leds", {24'h0, leds}, {24'h0, leds_m});
    chk("fault", {31'h0, fault}, {31'h0, fault_m});
  endtask

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_LED = 32'h8000_0008;
  localparam logic [31:0] A_CYC = 32'h8000_000C;

  initial begin
    logic [31:0] c0;
    logic [31:0] a;
    int unsigned sel;
    for (int i = 0; i < 1024; i++) ram_w[i] = 1'b0;

    cur_tag = "reset";
    step(1, A_ST, 0, 0, 0);
    step(1, A_ST, 0, 0, 0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_leds", {24'h0, leds}, 32'h0);
    step(0, A_ST, 0, 0, 0);
    chk("rst_status", data_out, 32'h0000_0001);

    cur_tag = "t1";
    step(0, 32'h10, 32'hDEAD_BEEF, 1, 0);
    step(0, 32'h10, 0, 0, 0);
    chk("read10", data_out, 32'hDEAD_BEEF);
    step(0, 32'h13, 0, 0, 0);
    chk("read13", data_out, 32'hDEAD_BEEF);

    cur_tag = "t2";
    step(0, 32'h20, 32'hAAAA_AAAA, 1, 0);
    step(0, 32'h20, 32'h1234_5678, 1, 0);
    chk("same_edge_old", data_out, 32'hAAAA_AAAA);
    step(0, 32'h20, 0, 0, 0);
    chk("new", data_out, 32'h1234_5678);

    cur_tag = "t3";
    for (int i = 0; i < 9; i++) step(0, A_TX, 32'h41 + i, 1, 0);
    step(0, A_ST, 0, 0, 0);
    chk("status_full", data_out, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      chk("head_order", {24'h0, tx_data}, 32'h41 + i);
      step(0, 32'h10, 0, 0, 1);
    end
    chk("drained_valid", {31'h0, tx_valid}, 32'h0);
    step(0, A_ST, 0, 0, 1);
    chk("status_empty", data_out, 32'h0000_0005);

    cur_tag = "t4";
    step(0, A_ST, 32'h4, 1, 0);
    for (int i = 0; i < 8; i++) step(0, A_TX, 32'h61 + i, 1, 0);
    step(0, A_TX, 32'h5A, 1, 1);
    step(0, A_ST, 0, 0, 0);
    chk("status_no_ovf", data_out, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", {24'h0, tx_data}, (i < 7) ? 32'h62 + i : 32'h5A);
      step(0, 32'h10, 0, 0, 1);
    end

    cur_tag = "t5";
    step(0, A_CYC, 0, 0, 0);
    c0 = data_out;
    for (int i = 0; i < 9; i++) step(0, 32'h10, 0, 0, 0);
    step(0, A_CYC, 0, 0, 0);
    chk("cycle_diff", data_out - c0, 32'd10);
    dep_en = 1'b1; dep_val = 32'hFFFF_FFFE;
    step(0, A_CYC, 32'h5, 1, 0);
    step(0, A_CYC, 0, 0, 0);
    chk("cycle_max", data_out, 32'hFFFF_FFFF);
    step(0, A_CYC, 0, 0, 0);
    chk("cycle_wrap", data_out, 32'h0);

    cur_tag = "t6";
    step(0, A_LED, 32'h1FF, 1, 0);
    chk("leds_ff", {24'h0, leds}, 32'hFF);
    step(0, A_LED, 0, 0, 0);
    chk("leds_read", data_out, 32'hFF);
    step(0, 32'h4000_0000, 32'h123, 1, 0);
    chk("unmapped_read", data_out, 32'h0);
    chk("unmapped_fault", {31'h0, fault}, 32'h1);
    step(0, A_TX, 32'h11, 1, 0);
    step(1, A_TX, 32'h77, 1, 0);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_leds6", {24'h0, leds}, 32'h0);
    step(1, 32'h10, 32'h0BAD_0BAD, 1, 0);
    step(0, 32'h10, 0, 0, 0);
    chk("ram_kept", data_out, 32'hDEAD_BEEF);

    cur_tag = "rand";
    for (int i = 0; i < 16; i++) step(0, 32'(i * 4), $urandom, 1, 0);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (sel <= 8) a = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h4000_0000;
          1:       a = 32'h8000_1000;
          default: a = 32'h0000_1000;
        endcase
      end
      step(($urandom_range(0, 24) == 0), a, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
